// File: rtl/activ4_pkg.sv
// Shared Activity 4 types: debouncer state encoding and the downstream Mealy FSM states.
package activ4_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'b00,
    S_RISE_WAIT = 2'b01,
    S_HIGH      = 2'b10,
    S_FALL_WAIT = 2'b11
  } dbnc_state_t;

  // Downstream FSM states, kept here so the debouncer and FSM benches agree.
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6,
    S7 = 3'd7
  } fsm_state_t;

endpackage

// File: rtl/activ4_x_debounce_sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit; synchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/activ4_x_debounce.sv
// Button debouncer producing level x plus rise/fall strobes for the Activity 4 FSM.
// DEBOUNCE_SYNC2_EN selects the two-flop synchronizer; otherwise a single sampling flop.
//
// state       | meaning
// S_LOW       | x=0, input stable low
// S_RISE_WAIT | x=0, counting consecutive high samples
// S_HIGH      | x=1, input stable high
// S_FALL_WAIT | x=1, counting consecutive low samples
module activ4_x_debounce
  import activ4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       x,
  output logic       x_rise,
  output logic       x_fall,
  output logic [1:0] state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic btn_s;

`ifdef DEBOUNCE_SYNC2_EN
  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_s)
  );
`else
  logic smp_q, smp_d;

  always_comb smp_d = btn_in;

  always_ff @(posedge clk) begin
    if (reset) smp_q <= 1'b0;
    else       smp_q <= smp_d;
  end

  assign btn_s = smp_q;
`endif

  dbnc_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (btn_s) begin
          state_d = S_RISE_WAIT;
          cnt_d   = '0;
        end
      end
      S_RISE_WAIT: begin
        if (!btn_s) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          x_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!btn_s) begin
          state_d = S_FALL_WAIT;
          cnt_d   = '0;
        end
      end
      S_FALL_WAIT: begin
        if (btn_s) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
          x_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
        x_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign x      = x_q;
  assign x_rise = rise_q;
  assign x_fall = fall_q;
  assign state  = state_q;

endmodule

// File: tb/tb_activ4_x_debounce.sv
// Randomized bench for activ4_x_debounce against a run-length model of the debounce rule.
module tb_activ4_x_debounce;

  localparam int N = 4;
`ifdef DEBOUNCE_SYNC2_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_in = 1'b1;
  logic       x, x_rise, x_fall;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  activ4_x_debounce #(.DEBOUNCE_CYCLES(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn_in),
    .x      (x),
    .x_rise (x_rise),
    .x_fall (x_fall),
    .state  (state)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: btn_s is btn_in delayed L edges; x toggles once N+1 consecutive
  // synchronized samples disagree with it, any agreeing sample restarts the run.
  logic [1:0] m_pipe = '0;
  logic       m_x = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
  int         m_run = 0;

  always @(posedge clk) begin
    logic s;
    if (reset) begin
      m_pipe = '0; m_x = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
    end else begin
      s = m_pipe[L-1];
      m_pipe = {m_pipe[0], btn_in};
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s != m_x) begin
        m_run++;
        if (m_run == N + 1) begin
          m_x    = ~m_x;
          m_rise = m_x;
          m_fall = ~m_x;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  bit chk_en = 1'b0;
  int rises_seen = 0;
  int falls_seen = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("x", int'(x), int'(m_x));
      check("x_rise", int'(x_rise), int'(m_rise));
      check("x_fall", int'(x_fall), int'(m_fall));
      check("state", int'(state), {m_x, (m_run > 0)});
      if (x_rise === 1'b1) rises_seen++;
      if (x_fall === 1'b1) falls_seen++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int edges;
    bit found;
    int r0, f0;

    // Reset held 2 cycles with the button pressed
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("rst_x", int'(x), 0);
      check("rst_state", int'(state), 0);
      check("rst_strobes", int'({x_rise, x_fall}), 0);
      @(negedge clk);
    end
    reset = 1'b0;
    btn_in = 1'b0;
    step(8);

    // Bounce: 3 high, 1 low, 3 high, low
    r0 = rises_seen;
    btn_in = 1'b1; step(3);
    btn_in = 1'b0; step(1);
    btn_in = 1'b1; step(3);
    btn_in = 1'b0; step(8);
    check("bounce_x", int'(x), 0);
    check("bounce_state", int'(state), 0);
    check("bounce_no_rise", rises_seen, r0);

    // Clean press: x rises L+N+1 edges after btn_in changes
    btn_in = 1'b1;
    edges = 0; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      edges++;
      if (x === 1'b1) found = 1'b1;
    end
    check("press_latency", edges, L + N + 1);
    check("press_rise", int'(x_rise), 1);
    @(posedge clk); #1;
    check("press_rise_once", int'(x_rise), 0);
    check("press_hold", int'(x), 1);
    @(negedge clk);
    step(3);

    // Clean release
    btn_in = 1'b0;
    edges = 0; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      edges++;
      if (x === 1'b0) found = 1'b1;
    end
    check("release_latency", edges, L + N + 1);
    check("release_fall", int'(x_fall), 1);
    @(posedge clk); #1;
    check("release_fall_once", int'(x_fall), 0);
    @(negedge clk);

    // Press again, then glitchy release that never completes
    btn_in = 1'b1; step(12);
    check("repress_x", int'(x), 1);
    f0 = falls_seen;
    btn_in = 1'b0; step(3);
    btn_in = 1'b1; step(2);
    btn_in = 1'b0; step(2);
    btn_in = 1'b1; step(8);
    check("glitch_x", int'(x), 1);
    check("glitch_state", int'(state), 2);
    check("glitch_no_fall", falls_seen, f0);

    // Reset mid rise-debounce with cnt=2
    btn_in = 1'b0; step(12);
    btn_in = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (state === 2'b01) found = 1'b1;
    end
    check("rw_reached", int'(found), 1);
    step(2);
    check("rw_still", int'(state), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_state", int'(state), 0);
    check("midrst_x", int'(x), 0);
    check("midrst_nofall", int'(x_fall), 0);
    @(negedge clk);
    reset = 1'b0;
    btn_in = 1'b0;
    step(5);

    // Random runs of 1..9 cycles with occasional resets
    for (int i = 0; i < 800; i++) begin
      btn_in = 1'($urandom_range(0, 1));
      reset  = ($urandom_range(0, 39) == 0);
      step(1);
      reset = 1'b0;
      step($urandom_range(0, 8));
    end
    btn_in = 1'b0;
    step(12);
    check("final_x", int'(x), 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
